// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single data-cache request port between committed stores
//   (buffered in a small FIFO store queue) and loads from the LSU.
//   Stores have priority by default. A bounded-wait counter promotes a
//   starving load to priority. A word-address hazard check stops a load
//   from overtaking a queued or arriving store to the same word.
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   commit_*          : committed store in; commit_ready = queue not full
//   load_*            : load request in; load_blocked = no grant this cycle
//   store_grant       : port used by the queue head this cycle
//   dc_ready          : cache accepts a request this cycle
//   dc_*              : request to the cache (unused fields driven to 0)
//   sq_count/sq_empty : store-queue occupancy
module dcache_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned R_WIDTH    = 6,
  parameter int unsigned MICROOP    = 5,
  parameter int unsigned ROB_TICKET = 3,
  parameter int unsigned SQ_DEPTH   = 4,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            commit_valid,
  input  logic [ADDR_BITS-1:0]            commit_address,
  input  logic [DATA_WIDTH-1:0]           commit_data,
  input  logic [MICROOP-1:0]              commit_microop,
  output logic                            commit_ready,
  input  logic                            load_valid,
  input  logic [ADDR_BITS-1:0]            load_addr,
  input  logic [R_WIDTH-1:0]              load_dest,
  input  logic [MICROOP-1:0]              load_microop,
  input  logic [ROB_TICKET-1:0]           load_ticket,
  output logic                            load_blocked,
  output logic                            store_grant,
  input  logic                            dc_ready,
  output logic                            dc_valid,
  output logic                            dc_is_store,
  output logic [ADDR_BITS-1:0]            dc_addr,
  output logic [DATA_WIDTH-1:0]           dc_data,
  output logic [MICROOP-1:0]              dc_microop,
  output logic [R_WIDTH-1:0]              dc_dest,
  output logic [ROB_TICKET-1:0]           dc_ticket,
  output logic [$clog2(SQ_DEPTH+1)-1:0]   sq_count,
  output logic                            sq_empty
);

  localparam int unsigned PW = $clog2(SQ_DEPTH);
  localparam int unsigned CW = $clog2(SQ_DEPTH+1);
  localparam int unsigned WW = $clog2(MAX_WAIT+1);

  typedef enum logic {STORE_PRI, LOAD_PRI} state_t;

  state_t                r_state, w_state_nxt;
  logic [WW-1:0]         r_wait, w_wait_nxt;

  logic [ADDR_BITS-1:0]  r_sq_addr [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_sq_data [SQ_DEPTH];
  logic [MICROOP-1:0]    r_sq_uop  [SQ_DEPTH];
  logic [SQ_DEPTH-1:0]   r_sq_vld;
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;

  logic w_push, w_pop, w_full;
  logic w_q_match, w_addr_match, w_hazard;
  logic w_store_grant, w_load_grant;

  assign w_full       = (r_count == CW'(SQ_DEPTH));
  assign commit_ready = ~w_full;
  assign sq_count     = r_count;
  assign sq_empty     = (r_count == '0);
  assign w_push       = commit_valid & ~w_full;
  assign w_pop        = w_store_grant;

  // Word-address compare against every live queue entry.
  always_comb begin
    w_q_match = 1'b0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (r_sq_vld[i] && (r_sq_addr[i][ADDR_BITS-1:2] == load_addr[ADDR_BITS-1:2]))
        w_q_match = 1'b1;
    end
  end

  // The address match alone drives load_blocked so that it stays
  // independent of load_valid; the FSM uses the load_valid-qualified form.
  assign w_addr_match = w_q_match |
                        (commit_valid & (commit_address[ADDR_BITS-1:2] == load_addr[ADDR_BITS-1:2]));
  assign w_hazard     = load_valid & w_addr_match;

  assign w_store_grant = ~rst & dc_ready & ~sq_empty & (r_state == STORE_PRI);
  assign store_grant   = w_store_grant;
  assign load_blocked  = rst | ~dc_ready | w_addr_match | w_store_grant;
  assign w_load_grant  = load_valid & ~load_blocked;

  always_comb begin
    dc_valid    = w_store_grant | w_load_grant;
    dc_is_store = 1'b0;
    dc_addr     = load_addr;
    dc_data     = '0;
    dc_microop  = load_microop;
    dc_dest     = load_dest;
    dc_ticket   = load_ticket;
    if (w_store_grant) begin
      dc_is_store = 1'b1;
      dc_addr     = r_sq_addr[r_head];
      dc_data     = r_sq_data[r_head];
      dc_microop  = r_sq_uop[r_head];
      dc_dest     = '0;
      dc_ticket   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_sq_addr[r_tail] <= commit_address;
      r_sq_data[r_tail] <= commit_data;
      r_sq_uop[r_tail]  <= commit_microop;
    end
  end

  // Push and pop never target the same slot: that would need the queue
  // both full (push refused) and non-empty at the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_sq_vld <= '0;
    end else begin
      if (w_push) begin
        r_sq_vld[r_tail] <= 1'b1;
        r_tail           <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_sq_vld[r_head] <= 1'b0;
        r_head           <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STORE_PRI;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      STORE_PRI: begin
        if (load_valid && !w_hazard && w_store_grant) begin
          if (r_wait == WW'(MAX_WAIT-1)) begin
            w_state_nxt = LOAD_PRI;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait + WW'(1);
          end
        end else begin
          w_wait_nxt = '0;
        end
      end
      LOAD_PRI: begin
        w_wait_nxt = '0;
        // Hazard exit lets the matching store drain instead of deadlocking.
        if (dc_ready && (w_load_grant || !load_valid || w_hazard))
          w_state_nxt = STORE_PRI;
      end
      default: begin
        w_state_nxt = STORE_PRI;
        w_wait_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter
//   Directed-vector bench for dcache_port_arbiter with hand-computed
//   expectations. Inputs change on the falling edge; outputs are sampled
//   1 time unit later, well away from the rising edge.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_address;
  logic [31:0] commit_data;
  logic [4:0]  commit_microop;
  logic        commit_ready;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [5:0]  load_dest;
  logic [4:0]  load_microop;
  logic [2:0]  load_ticket;
  logic        load_blocked;
  logic        store_grant;
  logic        dc_ready;
  logic        dc_valid;
  logic        dc_is_store;
  logic [31:0] dc_addr;
  logic [31:0] dc_data;
  logic [4:0]  dc_microop;
  logic [5:0]  dc_dest;
  logic [2:0]  dc_ticket;
  logic [2:0]  sq_count;
  logic        sq_empty;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .DATA_WIDTH(32), .ADDR_BITS(32), .R_WIDTH(6), .MICROOP(5),
    .ROB_TICKET(3), .SQ_DEPTH(4), .MAX_WAIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_address(commit_address),
    .commit_data(commit_data), .commit_microop(commit_microop),
    .commit_ready(commit_ready),
    .load_valid(load_valid), .load_addr(load_addr), .load_dest(load_dest),
    .load_microop(load_microop), .load_ticket(load_ticket),
    .load_blocked(load_blocked), .store_grant(store_grant),
    .dc_ready(dc_ready), .dc_valid(dc_valid), .dc_is_store(dc_is_store),
    .dc_addr(dc_addr), .dc_data(dc_data), .dc_microop(dc_microop),
    .dc_dest(dc_dest), .dc_ticket(dc_ticket),
    .sq_count(sq_count), .sq_empty(sq_empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle of stimulus; store data is derived from its address.
  task automatic step(input logic cv, input logic [31:0] ca, input logic lv,
                      input logic [31:0] la, input logic rdy);
    @(negedge clk);
    rst            = 1'b0;
    commit_valid   = cv;
    commit_address = ca;
    commit_data    = 32'hD000_0000 | ca;
    load_valid     = lv;
    load_addr      = la;
    dc_ready       = rdy;
    #1;
  endtask

  task automatic exp_store(input string tag, input logic [31:0] a);
    check({tag, ".sg"},   store_grant, 1'b1);
    check({tag, ".dv"},   dc_valid,    1'b1);
    check({tag, ".st"},   dc_is_store, 1'b1);
    check({tag, ".addr"}, dc_addr,     a);
    check({tag, ".data"}, dc_data,     32'hD000_0000 | a);
    check({tag, ".uop"},  dc_microop,  5'd2);
    check({tag, ".dest"}, dc_dest,     6'd0);
    check({tag, ".tkt"},  dc_ticket,   3'd0);
  endtask

  task automatic exp_load(input string tag, input logic [31:0] a);
    check({tag, ".sg"},   store_grant,  1'b0);
    check({tag, ".lb"},   load_blocked, 1'b0);
    check({tag, ".dv"},   dc_valid,     1'b1);
    check({tag, ".st"},   dc_is_store,  1'b0);
    check({tag, ".addr"}, dc_addr,      a);
    check({tag, ".data"}, dc_data,      32'h0);
    check({tag, ".uop"},  dc_microop,   5'd9);
    check({tag, ".dest"}, dc_dest,      6'd17);
    check({tag, ".tkt"},  dc_ticket,    3'd5);
  endtask

  task automatic exp_idle(input string tag);
    check({tag, ".empty"}, sq_empty, 1'b1);
    check({tag, ".cnt"},   sq_count, 3'd0);
    check({tag, ".dv"},    dc_valid, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_address = '0; commit_data = '0;
    commit_microop = 5'd2; load_valid = 1'b0; load_addr = '0;
    load_dest = 6'd17; load_microop = 5'd9; load_ticket = 3'd5; dc_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    check("rst.sg", store_grant, 1'b0);
    check("rst.dv", dc_valid, 1'b0);
    check("rst.lb", load_blocked, 1'b1);
    step(0, 0, 0, 0, 1);
    check("rst.cnt", sq_count, 3'd0);
    check("rst.empty", sq_empty, 1'b1);
    check("rst.cr", commit_ready, 1'b1);
    check("rst.lb_off", load_blocked, 1'b0);

    // 1: four back-to-back commits issue in order, one cycle after push
    step(1, 32'h100, 0, 0, 1); check("t1.c1.dv", dc_valid, 1'b0);
    step(1, 32'h104, 0, 0, 1); exp_store("t1.c2", 32'h100);
    step(1, 32'h108, 0, 0, 1); exp_store("t1.c3", 32'h104);
    check("t1.c3.cnt", sq_count, 3'd1);
    step(1, 32'h10C, 0, 0, 1); exp_store("t1.c4", 32'h108);
    step(0, 0, 0, 0, 1);       exp_store("t1.c5", 32'h10C);
    step(0, 0, 0, 0, 1);       exp_idle("t1.c6");

    // 2: fill while cache stalls; fifth commit refused
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h500 + 32'(4*k), 0, 0, 0);
      check($sformatf("t2.cr%0d", k), commit_ready, (k < 4) ? 1'b1 : 1'b0);
      check($sformatf("t2.sg%0d", k), store_grant, 1'b0);
    end
    check("t2.lb", load_blocked, 1'b1);
    step(0, 0, 0, 0, 0);
    check("t2.cnt", sq_count, 3'd4);
    check("t2.cr", commit_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1);
      exp_store($sformatf("t2.d%0d", k), 32'h500 + 32'(4*k));
    end
    step(0, 0, 0, 0, 1); exp_idle("t2.end");

    // 3: starving load promoted after MAX_WAIT blocked cycles
    step(1, 32'h600, 0, 32'h200, 1); check("t3.c1.dv", dc_valid, 1'b0);
    step(1, 32'h604, 1, 32'h200, 1); exp_store("t3.c2", 32'h600);
    check("t3.c2.lb", load_blocked, 1'b1);
    step(1, 32'h608, 1, 32'h200, 1); exp_store("t3.c3", 32'h604);
    check("t3.c3.lb", load_blocked, 1'b1);
    step(1, 32'h60C, 1, 32'h200, 1); exp_store("t3.c4", 32'h608);
    check("t3.c4.lb", load_blocked, 1'b1);
    step(1, 32'h610, 1, 32'h200, 1); exp_load("t3.c5", 32'h200);
    check("t3.c5.cnt", sq_count, 3'd1);
    step(0, 0, 0, 0, 1); exp_store("t3.c6", 32'h60C);
    step(0, 0, 0, 0, 1); exp_store("t3.c7", 32'h610);
    step(0, 0, 0, 0, 1); exp_idle("t3.end");

    // 4: hazard cycle does not advance the wait counter
    step(1, 32'h300, 0, 32'h302, 1); check("t4.c1.dv", dc_valid, 1'b0);
    step(1, 32'h710, 1, 32'h302, 1); exp_store("t4.c2", 32'h300);
    check("t4.c2.lb", load_blocked, 1'b1);
    step(1, 32'h714, 1, 32'h302, 1); exp_store("t4.c3", 32'h710);
    step(1, 32'h718, 1, 32'h302, 1); exp_store("t4.c4", 32'h714);
    step(1, 32'h71C, 1, 32'h302, 1); exp_store("t4.c5", 32'h718);
    check("t4.c5.lb", load_blocked, 1'b1);
    step(0, 0, 1, 32'h302, 1); exp_load("t4.c6", 32'h302);
    step(0, 0, 0, 0, 1); exp_store("t4.c7", 32'h71C);
    step(0, 0, 0, 0, 1); exp_idle("t4.end");

    // 5: same-word commit arriving alongside the load blocks it
    step(1, 32'h402, 1, 32'h400, 1);
    check("t5.c1.sg", store_grant, 1'b0);
    check("t5.c1.lb", load_blocked, 1'b1);
    check("t5.c1.dv", dc_valid, 1'b0);
    step(0, 0, 1, 32'h400, 1); exp_store("t5.c2", 32'h402);
    check("t5.c2.lb", load_blocked, 1'b1);
    step(0, 0, 1, 32'h400, 1); exp_load("t5.c3", 32'h400);
    // different word (0x404) is not a hazard
    step(1, 32'h404, 1, 32'h400, 1); exp_load("t5.c4", 32'h400);
    step(0, 0, 0, 0, 1); exp_store("t5.c5", 32'h404);
    step(0, 0, 0, 0, 1); exp_idle("t5.end");

    // 6: reset with queued entries discards them
    step(1, 32'h900, 0, 0, 0);
    step(1, 32'h904, 0, 0, 0);
    step(1, 32'h908, 0, 0, 0);
    step(0, 0, 0, 0, 0); check("t6.cnt3", sq_count, 3'd3);
    @(negedge clk);
    rst = 1'b1; dc_ready = 1'b1; #1;
    check("t6.rst.dv", dc_valid, 1'b0);
    check("t6.rst.sg", store_grant, 1'b0);
    check("t6.rst.lb", load_blocked, 1'b1);
    step(1, 32'h800, 0, 0, 1); exp_idle("t6.post");
    step(0, 0, 0, 0, 1); exp_store("t6.c2", 32'h800);
    step(0, 0, 0, 0, 1); exp_idle("t6.end");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
